// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
package display_pkg;

    // Default number of multiplexed digits.
    localparam int N_DIGITS_DEFAULT = 8;

    // One hexadecimal/BCD digit as presented to the segment decoder.
    typedef logic [3:0] nibble_t;

endpackage : display_pkg

// File: rtl/tick_gen.sv
// Prescaler: counts 0..COUNT_MAX-1 and flags the last count of each period.
// With COUNT_MAX=1 the counter stays at 0 and tick is high every cycle.
module tick_gen #(
    parameter int COUNT_MAX = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(COUNT_MAX - 1);

    logic [CW-1:0] r_count;

    // Free-running period counter, wraps after the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST_COUNT);

endmodule : tick_gen

// File: rtl/display_mux_scan.sv
// Time-multiplexed seven-segment digit scanner.
// A new value is captured into a pending register on load and only copied
// into the displayed register at a frame boundary, so a frame never shows a
// mix of old and new digits. digit_out feeds an external segment decoder.
// Optional feature: define LEADING_ZERO_BLANK_EN to switch off the anode of
// leading-zero digits (digit 0 is always shown).
module display_mux_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS  = N_DIGITS_DEFAULT,
    parameter int COUNT_MAX = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value_in,
    output logic [3:0]              digit_out,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_done
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

    logic [IW-1:0]          r_idx;
    logic [4*N_DIGITS-1:0]  r_pending;
    logic [4*N_DIGITS-1:0]  r_display;
    nibble_t                r_digit;
    logic [N_DIGITS-1:0]    r_anodes;
    logic                   r_frame_done;

    logic                   w_tick;
    logic                   w_boundary;
    logic [IW-1:0]          w_idx_next;
    logic [4*N_DIGITS-1:0]  w_disp_next;
    nibble_t                w_nib [N_DIGITS];
    logic [N_DIGITS-1:0]    w_onehot;
    logic                   w_blank;

    tick_gen #(
        .COUNT_MAX (COUNT_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // The idx wrap from the last digit back to 0 marks the frame boundary.
    assign w_boundary = w_tick && (r_idx == LAST_IDX);
    assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);

    // Value shown from the next edge on; a load coinciding with the
    // boundary bypasses the pending register so it appears immediately.
    assign w_disp_next = !w_boundary ? r_display :
                         (load ? value_in : r_pending);

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = w_disp_next[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // w_upper_zero[k] is high when digits k..N_DIGITS-1 are all zero.
    logic [N_DIGITS-1:0] w_upper_zero;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_zero
            if (gi == N_DIGITS - 1) begin : g_top
                assign w_upper_zero[gi] = (w_nib[gi] == 4'h0);
            end else begin : g_chain
                assign w_upper_zero[gi] = (w_nib[gi] == 4'h0) && w_upper_zero[gi+1];
            end
        end
    endgenerate
    assign w_blank = (w_idx_next != '0) && w_upper_zero[w_idx_next];
`else
    assign w_blank = 1'b0;
`endif

    assign w_onehot = N_DIGITS'(1) << w_idx_next;

    // Scan state: advance digit and refresh anode/digit outputs on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= LAST_IDX;
            r_anodes     <= '1;
            r_digit      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_idx    <= w_idx_next;
                r_digit  <= w_nib[w_idx_next];
                r_anodes <= w_blank ? '1 : ~w_onehot;
            end
        end
    end

    // Double-buffered digit value: pending follows load, display swaps at frame boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_display <= '0;
        end else begin
            if (load) begin
                r_pending <= value_in;
            end
            if (w_boundary) begin
                r_display <= w_disp_next;
            end
        end
    end

    assign digit_out  = r_digit;
    assign anodes     = r_anodes;
    assign frame_done = r_frame_done;

endmodule : display_mux_scan

// File: tb/tb_display_mux_scan.sv
// Directed testbench for display_mux_scan with N_DIGITS=8, COUNT_MAX=4.
module tb_display_mux_scan;

    localparam int N  = 8;
    localparam int CM = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [31:0]  value_in = '0;
    logic [3:0]   digit_out;
    logic [7:0]   anodes;
    logic         frame_done;

    int n_cmp = 0;
    int n_err = 0;

    display_mux_scan #(
        .N_DIGITS  (N),
        .COUNT_MAX (CM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value_in   (value_in),
        .digit_out  (digit_out),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    // Expected anodes for a slot whose digit and all digits above are zero.
    function automatic logic [7:0] an_lz(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        return (k == 0) ? an_of(0) : 8'hFF;
`else
        return an_of(k);
`endif
    endfunction

    task automatic check_slot(input string tag, input int k, input logic [3:0] d,
                              input logic [7:0] an, input logic fd);
        check_val($sformatf("%s%0d_an", tag, k), {24'h0, anodes}, {24'h0, an});
        check_val($sformatf("%s%0d_dig", tag, k), {28'h0, digit_out}, {28'h0, d});
        check_val($sformatf("%s%0d_fd", tag, k), {31'h0, frame_done}, {31'h0, fd});
    endtask

    // Move from one slot's update point to the next, optionally loading
    // in the first cycle of the slot (never a frame boundary).
    task automatic advance(input bit do_load, input logic [31:0] v);
        if (do_load) begin
            load     = 1'b1;
            value_in = v;
        end
        step;
        load = 1'b0;
        repeat (CM - 1) step;
    endtask

    // Release reset, load v in cycle 1, stop just after the first tick edge.
    task automatic release_and_load(input logic [31:0] v);
        reset = 1'b0;
        step;
        load     = 1'b1;
        value_in = v;
        step;
        load = 1'b0;
        step;
        check_val("pre_tick_an", {24'h0, anodes}, 32'hFF);
        check_val("pre_tick_fd", {31'h0, frame_done}, 32'h0);
        step;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_val("rst_an", {24'h0, anodes}, 32'hFF);
        check_val("rst_dig", {28'h0, digit_out}, 32'h0);
        check_val("rst_fd", {31'h0, frame_done}, 32'h0);
        repeat (3) step;

        // Frame 1: 0x76543210
        release_and_load(32'h76543210);
        check_slot("f1s", 0, 4'h0, 8'hFE, 1'b1);
        step;
        check_val("hold_an", {24'h0, anodes}, 32'hFE);
        check_val("hold_fd", {31'h0, frame_done}, 32'h0);
        repeat (CM - 1) step;
        for (int k = 1; k < 8; k++) begin
            check_slot("f1s", k, 4'(k), an_of(k), 1'b0);
            if (k < 7) advance(k == 3, 32'hFEDCBA98);
        end

        // Frame 2: load taken during digit 3 of frame 1 appears now.
        for (int k = 0; k < 8; k++) begin
            advance(1'b0, 32'h0);
            check_slot("f2s", k, 4'(8 + k), an_of(k), k == 0);
        end

        // Load exactly in the frame-boundary cycle.
        repeat (CM - 1) step;
        load     = 1'b1;
        value_in = 32'h11111111;
        step;
        load = 1'b0;
        check_slot("f3s", 0, 4'h1, 8'hFE, 1'b1);
        for (int k = 1; k < 6; k++) begin
            advance(1'b0, 32'h0);
            check_slot("f3s", k, 4'h1, an_of(k), 1'b0);
        end

        // Reset during digit-5 slot, observed between clock edges.
        step;
        #2 reset = 1'b1;
        #1;
        check_val("arst_an", {24'h0, anodes}, 32'hFF);
        check_val("arst_dig", {28'h0, digit_out}, 32'h0);
        check_val("arst_fd", {31'h0, frame_done}, 32'h0);
        step;
        step;

        // Restart with 0x00000305 (leading zeros in digits 3..7).
        release_and_load(32'h00000305);
        check_slot("f4s", 0, 4'h5, 8'hFE, 1'b1);
        advance(1'b0, 32'h0);
        check_slot("f4s", 1, 4'h0, an_of(1), 1'b0);
        advance(1'b0, 32'h0);
        check_slot("f4s", 2, 4'h3, an_of(2), 1'b0);
        for (int k = 3; k < 8; k++) begin
            advance(1'b0, 32'h0);
            check_slot("f4s", k, 4'h0, an_lz(k), 1'b0);
            if (k == 4) begin
                load     = 1'b1;
                value_in = 32'h0;
                step;
                load = 1'b0;
                repeat (CM - 1) step;
                k++;
                check_slot("f4s", k, 4'h0, an_lz(k), 1'b0);
            end
        end

        // All-zero display: digit 0 always shown.
        advance(1'b0, 32'h0);
        check_slot("f5s", 0, 4'h0, an_lz(0), 1'b1);
        advance(1'b0, 32'h0);
        check_slot("f5s", 1, 4'h0, an_lz(1), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_display_mux_scan

// File: doc/display_mux_scan.md
DISPLAY_MUX_SCAN -- requirements
Module: display_mux_scan

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed seven-segment digits.
REQ-002 Parameter COUNT_MAX, default 100000: clock cycles per digit slot; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; capture value_in.
REQ-006 value_in  input  4*N_DIGITS  packed nibbles; digit k = value_in[4k+3:4k], digit 0 rightmost.
REQ-007 digit_out  output  4  nibble for the active digit; feeds the BCD-to-seven-segment decoder input.
REQ-008 anodes  output  N_DIGITS  active-low digit enables; at most one bit low.
REQ-009 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-010 The prescaler counts 0..COUNT_MAX-1, wraps to 0, and asserts an internal tick in the cycle the count equals COUNT_MAX-1.
REQ-011 With COUNT_MAX=1, tick is asserted every cycle.
REQ-012 Digit index idx advances by 1 on each tick and wraps N_DIGITS-1 -> 0.
REQ-013 The wrap of idx from N_DIGITS-1 to 0 is the frame boundary.
REQ-014 load=1 writes value_in into the pending register on that edge; pending is otherwise held.
REQ-015 At a frame boundary, the display register takes pending; if load=1 in the same cycle, the display register takes value_in directly.
REQ-016 A load outside a frame boundary never changes digits already displayed in the current frame (no tearing).
REQ-017 On each tick, anodes <= ~(1 << new idx) and digit_out <= display nibble[new idx], both registered in the same edge.
REQ-018 Latency from tick cycle to updated anodes/digit_out: 1 clock.
REQ-019 Between ticks, anodes and digit_out are held.
REQ-020 frame_done is high for exactly the cycle following the frame-boundary edge, i.e. aligned with digit 0 first being driven.

Reset
REQ-021 reset=1 asynchronously forces: prescaler=0, idx=N_DIGITS-1, pending=0, display=0, anodes=all ones, digit_out=0, frame_done=0.
REQ-022 After reset release, the first tick is a frame boundary and activates digit 0.
REQ-023 Reset mid-frame discards pending and display contents; no partial frame completes.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, during the slot of digit k>0 with all display nibbles k..N_DIGITS-1 equal to zero, anodes are all ones; digit_out still carries the nibble; digit 0 is never blanked.
REQ-025 Without LEADING_ZERO_BLANK_EN, every digit slot drives its anode low.

Structure
REQ-026 Package display_pkg holds the N_DIGITS default constant and typedef nibble_t (logic [3:0]).
REQ-027 Prescaler implemented as sub-module tick_gen (parameter COUNT_MAX; ports clk, reset, tick).
REQ-028 The seven-segment decoder is not instantiated inside this block; digit_out connects to it at the top level.

Verification (N_DIGITS=8, COUNT_MAX=4)
REQ-029 Release reset, load 0x76543210 at cycle 1 -> first tick at cycle 3; cycle 4: anodes=8'hFE, digit_out=0, frame_done=1; every 4 cycles after, anodes low bit shifts left and digit_out=1,2,...,7; then wraps to 8'hFE with frame_done.
REQ-030 While displaying 0x76543210, load 0xFEDCBA98 during the digit-3 slot -> digits 4..7 still show 4..7; the next frame shows 8,9,A,...,F.
REQ-031 Load 0x11111111 in the exact frame-boundary cycle -> digit_out=1 in the first slot of that frame.
REQ-032 Assert reset during the digit-5 slot -> anodes=8'hFF and digit_out=0 with no clock edge; after release, restart per REQ-029.
REQ-033 LEADING_ZERO_BLANK_EN defined, display 0x00000305 -> digits 0..2 enabled (5,0,3), digits 3..7 slots anodes=8'hFF; display 0x0 -> only digit 0 enabled, showing 0.
REQ-034 LEADING_ZERO_BLANK_EN undefined, display 0x00000305 -> all 8 slots enable their anode.
